// File: rtl/upsample2x_nearest.sv
// 2x nearest-neighbour upsampler: each pixel is repeated horizontally and each
// row is replayed from a line buffer, giving a 2W x 2H plane from a W x H plane.
module upsample2x_nearest #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic {
        PASS,
        REPLAY
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  dup_q, dup_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  eol_q, eol_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] linebuf_q [IMG_W];

    logic adv;
    logic in_fire;

    assign adv      = !valid_q || out_ready;
    assign in_ready = !rst && (state_q == PASS) && !dup_q && adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dup_d   = dup_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q;
        eol_d   = eol_q;
        last_d  = last_q;
        if (adv) begin
            // Any beat not explicitly loaded below becomes a bubble.
            valid_d = 1'b0;
            eol_d   = 1'b0;
            last_d  = 1'b0;
            unique case (state_q)
                PASS: begin
                    if (!dup_q) begin
                        if (in_fire) begin
                            data_d  = in_data;
                            valid_d = 1'b1;
                            hold_d  = in_data;
                            dup_d   = 1'b1;
                        end
                    end else begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        dup_d   = 1'b0;
                        if (col_q == COL_MAX) begin
                            eol_d   = 1'b1;
                            col_d   = '0;
                            state_d = REPLAY;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                REPLAY: begin
                    data_d  = linebuf_q[col_q];
                    valid_d = 1'b1;
                    dup_d   = !dup_q;
                    if (dup_q) begin
                        if (col_q == COL_MAX) begin
                            eol_d   = 1'b1;
                            col_d   = '0;
                            state_d = PASS;
                            if (row_q == ROW_MAX) begin
                                last_d = 1'b1;
                                row_d  = '0;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PASS;
            col_q   <= '0;
            row_q   <= '0;
            dup_q   <= 1'b0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dup_q   <= dup_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
            last_q  <= last_d;
        end
    end

    // Line buffer needs no reset: every entry is written before it is replayed.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            linebuf_q[col_q] <= in_data;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_eol   = eol_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_upsample2x_nearest.sv
// Bench for upsample2x_nearest: a 4x2 instance for directed and stall tests,
// plus a default 20x20 instance for the ramp test.
module tb_upsample2x_nearest;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BW = 20;
    localparam int BH = 20;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eol;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_eol;
    logic          out_last;

    logic [DW-1:0] b_in_data = '0;
    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [DW-1:0] b_out_data;
    logic          b_out_valid;
    logic          b_out_ready = 1'b1;
    logic          b_out_eol;
    logic          b_out_last;

    upsample2x_nearest #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_last(out_last)
    );

    upsample2x_nearest #(.DATA_WIDTH(DW), .IMG_W(BW), .IMG_H(BH)) dut_big (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_eol(b_out_eol), .out_last(b_out_last)
    );

    beat_t sq[$];
    beat_t bq[$];
    int    cmp = 0;
    int    bad = 0;
    int    cyc = 0;
    int    beats = 0;
    int    b_beats = 0;
    int    b_hs = 0;
    int    gap_checks = 0;
    int    last_cyc = 0;
    bit    chk_en = 1'b0;
    bit    gap_chk = 1'b0;
    bit    rnd_rdy = 1'b0;
    bit    prev_last = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_b;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small-instance monitor: scoreboard pop, stall stability, plane gap.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_beat", 32'({out_data, out_eol, out_last}), 32'(prev_b));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (chk_en) begin
                    check("sb_nonempty", 32'(sq.size() > 0), 1);
                    if (sq.size() > 0) begin
                        e = sq.pop_front();
                        check("beat", 32'({out_data, out_eol, out_last}), 32'(e));
                    end
                    if (gap_chk && prev_last) begin
                        gap_checks++;
                        check("b2b_gap", 32'(cyc - last_cyc), 1);
                    end
                    prev_last = out_last;
                    last_cyc  = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = {out_data, out_eol, out_last};
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (b_in_valid && b_in_ready) b_hs++;
            if (b_out_valid && b_out_ready) begin
                b_beats++;
                check("big_nonempty", 32'(bq.size() > 0), 1);
                if (bq.size() > 0) begin
                    e = bq.pop_front();
                    check("big_beat", 32'({b_out_data, b_out_eol, b_out_last}), 32'(e));
                end
            end
        end
    end

    task automatic push_plane(input logic [DW-1:0] p [W*H]);
        beat_t b;
        for (int r = 0; r < H; r++)
            for (int rep = 0; rep < 2; rep++)
                for (int c = 0; c < W; c++)
                    for (int k = 0; k < 2; k++) begin
                        b.d    = p[r*W+c];
                        b.eol  = (c == W-1) && (k == 1);
                        b.last = b.eol && (rep == 1) && (r == H-1);
                        sq.push_back(b);
                    end
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_seen", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_plane(input logic [DW-1:0] p [W*H], input int gap);
        for (int i = 0; i < W*H; i++) send(p[i], gap);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sq.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(sq.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] p1 [W*H];
        logic [DW-1:0] p2 [W*H];
        beat_t         b;
        int            t;
        p1 = '{16'd1, 16'd2, 16'd3, 16'd4,
               16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
        for (int i = 0; i < W*H; i++) p2[i] = DW'(10 + i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_eol", 32'(out_eol), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed plane, full-rate output.
        chk_en = 1'b1;
        beats  = 0;
        push_plane(p1);
        send_plane(p1, 0);
        drain();
        check("t1_beats", 32'(beats), 32);

        // Random backpressure.
        beats   = 0;
        rnd_rdy = 1'b1;
        push_plane(p1);
        send_plane(p1, 0);
        drain();
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t2_beats", 32'(beats), 32);

        // Gapped input: 1 cycle on, 3 off.
        beats = 0;
        push_plane(p1);
        send_plane(p1, 3);
        drain();
        check("t3_beats", 32'(beats), 32);

        // Abandon a plane mid-frame with reset.
        chk_en = 1'b0;
        for (int i = 0; i < 5; i++) send(DW'(100 + i), 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        sq.delete();
        beats  = 0;
        chk_en = 1'b1;
        push_plane(p2);
        send_plane(p2, 0);
        drain();
        check("t4_beats", 32'(beats), 32);

        // Two planes back-to-back, no gap between them.
        beats      = 0;
        prev_last  = 1'b0;
        gap_chk    = 1'b1;
        gap_checks = 0;
        push_plane(p1);
        push_plane(p2);
        for (int i = 0; i < W*H; i++) send(p1[i], 0);
        for (int i = 0; i < W*H; i++) send(p2[i], 0);
        in_valid = 1'b0;
        drain();
        gap_chk = 1'b0;
        check("t5_beats", 32'(beats), 64);
        check("t5_gap_checks", 32'(gap_checks), 1);

        // Default-size ramp on the 20x20 instance.
        for (int r = 0; r < 2*BH; r++)
            for (int c = 0; c < 2*BW; c++) begin
                b.d    = DW'((r/2)*BW + c/2);
                b.eol  = (c == 2*BW-1);
                b.last = b.eol && (r == 2*BH-1);
                bq.push_back(b);
            end
        b_beats = 0;
        b_hs    = 0;
        for (int i = 0; i < BW*BH; i++) begin
            t = 0;
            b_in_data  = DW'(i);
            b_in_valid = 1'b1;
            @(negedge clk);
            while (!b_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        t = 0;
        while (bq.size() > 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("big_drain", 32'(bq.size()), 0);
        check("big_beats", 32'(b_beats), 4*BW*BH);
        check("big_handshakes", 32'(b_hs), BW*BH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/upsample2x_nearest.md
Name: upsample2x_nearest

Overview:
- Streaming 2x nearest-neighbour upsampler for the YOLOv5 neck (the nn.Upsample stage); spatially the inverse of the max-pool path.
- Takes one feature-map channel plane of IMG_W x IMG_H signed 16-bit pixels, row-major, over a valid/ready stream.
- Emits a 2*IMG_W x 2*IMG_H plane: each pixel is repeated horizontally, and each row is replayed once from an internal line buffer.
- Sits between the conv output stream and the concat/next conv input stream.

Parameters:
- DATA_WIDTH, 16, pixel width (signed fixed point, passed bit-exact).
- IMG_W, 20, input plane width in pixels (>=2).
- IMG_H, 20, input plane height in pixels (>=1).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- in_data, input, DATA_WIDTH, input pixel.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block accepts in_data this cycle.
- out_data, output, DATA_WIDTH, output pixel (registered).
- out_valid, output, 1, out_data valid (registered).
- out_ready, input, 1, downstream accepts out_data this cycle.
- out_eol, output, 1, qualifies out_data as the last pixel of an output row (registered).
- out_last, output, 1, qualifies out_data as the last pixel of the output plane (registered).

Behaviour:
- Reset (sync, rst=1 at posedge) values: out_valid=0, out_data=0, out_eol=0, out_last=0; state=PASS, col=0, row=0, dup=0. in_ready is 0 while rst=1. Line buffer contents are not cleared and are don't-care.
- Reset mid-frame abandons the frame. The next accepted input pixel is treated as pixel (0,0).
- adv = !out_valid || out_ready. The output register loads only when adv=1. While out_valid=1 and out_ready=0, out_data, out_eol and out_last hold stable.
- State PASS (first copy of an output row pair):
  - dup=0: in_ready=adv. On in_valid&&in_ready: out_data<=in_data, out_valid<=1, linebuf[col]<=in_data, hold<=in_data, dup<=1.
  - dup=1: in_ready=0. When adv: out_data<=hold, out_valid<=1, dup<=0. If col==IMG_W-1, set out_eol=1 on this beat, col<=0, state<=REPLAY; otherwise col<=col+1.
  - dup=0 with no input handshake and adv=1: out_valid<=0 (bubble).
- State REPLAY (second copy):
  - in_ready=0.
  - Each adv cycle emits linebuf[col] (combinational read of a register array), dup toggles, and col increments after the dup=1 beat.
  - The final beat (col==IMG_W-1, dup=1) sets out_eol=1. If row==IMG_H-1 it also sets out_last=1 and row<=0; otherwise row<=row+1. State then returns to PASS, col=0.
- out_eol/out_last are 0 on every beat other than those stated above.
- Latency: the first output beat is valid the cycle after the input handshake.
- Throughput: 1 output/cycle with out_ready=1. Input rate is 1 pixel per 2 cycles in PASS and 0 in REPLAY.
- Per input row: exactly 4*IMG_W output beats. Per plane: exactly 4*IMG_W*IMG_H beats.
- Back-to-back planes: no idle cycle is required. PASS of plane N+1 may accept input in the cycle after the out_last beat is loaded, provided adv=1.
- Width rules: col is clog2(IMG_W) bits and row is clog2(IMG_H) bits. Both wrap to 0 explicitly at the limits, never by overflow.
- Pixel values are never altered: negative values, 16'h8000 and 16'h7FFF pass through unchanged.

Test Plan:
- IMG_W=4, IMG_H=2, in row0={1,2,3,4}, row1={-1(16'hFFFF),16'h8000,16'h7FFF,0}, out_ready=1 -> 32 beats:
  - Rows 1 and 2: 1,1,2,2,3,3,4,4 (each).
  - Rows 3 and 4: FFFF,FFFF,8000,8000,7FFF,7FFF,0,0 (each).
  - out_eol on beats 8,16,24,32; out_last only on beat 32.
- Same stimulus with out_ready toggled by random pattern (50%) -> identical beat sequence. out_data/out_eol/out_last stay stable whenever out_valid=1 and out_ready=0. in_ready is never 1 in REPLAY.
- in_valid gapped (1 cycle on, 3 off) -> identical output sequence, out_valid=0 bubbles only. Beat count stays 4*W*H.
- Assert rst for 1 cycle after 5 input pixels of plane 1, then send a full plane {10..17} -> out_valid=0 the cycle after reset. The first output pair is 10,10 and the full 32-beat sequence is correct.
- Two planes back-to-back with in_valid=1 and out_ready=1 throughout -> 64 beats, out_last on beats 32 and 64. The first beat of plane 2 directly follows beat 32 with no gap.
- Default params (20x20), ramp input 0..399 -> 1600 beats. Output (r,c) equals input (r/2,c/2). in_ready is high for exactly 400 handshakes.
